// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the instruction prefetch queue.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side memory port plus decode-side valid/stall port of the prefetch queue.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ready;
  logic [31:0]     instr;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic            valid_d;
  logic            stall_d;
  logic [CW-1:0]   count;

  // master is the queue itself; slave is the memory/execute/decode environment
  modport master (
    output imem_addr, imem_req, instr_d, pc_d, valid_d, count,
    input  imem_ready, instr, redirect, redirect_pc, stall_d
  );

  modport slave (
    input  imem_addr, imem_req, instr_d, pc_d, valid_d, count,
    output imem_ready, instr, redirect, redirect_pc, stall_d
  );

endinterface

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry FIFO with wrapping pointers, occupancy count and a
// synchronous clear that overrides any same-cycle push or pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  entry_t                 wdata_i,
  output entry_t                 rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // a full FIFO may still accept a write when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues sequential fetches while
// there is room, and hands {PC, instr} pairs to decode; redirect flushes and restarts.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN    = fetch_pkg::XLEN,
  parameter int              DEPTH   = 4,
  parameter logic [XLEN-1:0] PC_INIT = XLEN'(32'h0040_0000)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.master fq
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  entry_t          wr_entry, head;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic            pop, req, push;
  logic            unused_pc_lsbs;

  assign pop  = ~empty & ~fq.stall_d;
  // reset gates the request combinationally so it drops without waiting for an edge
  assign req  = (~full | pop) & ~fq.redirect & ~rst_i;
  assign push = req & fq.imem_ready;

  assign wr_entry = '{pc: fetch_pc_q, instr: fq.instr};

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (fq.redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (fq.redirect)  fetch_pc_d = {fq.redirect_pc[XLEN-1:2], 2'b00};
    else if (push)    fetch_pc_d = fetch_pc_q + XLEN'(4);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) fetch_pc_q <= PC_INIT;
    else       fetch_pc_q <= fetch_pc_d;
  end

  assign unused_pc_lsbs = ^fq.redirect_pc[1:0];

  assign fq.imem_addr = fetch_pc_q;
  assign fq.imem_req  = req;
  assign fq.valid_d   = ~empty;
  assign fq.instr_d   = empty ? NOP_INSTR : head.instr;
  assign fq.pc_d      = empty ? '0 : head.pc;
  assign fq.count     = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int          XLEN    = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] PC_INIT = 32'h0040_0000;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  ent_t        mq[$];
  logic [31:0] m_pc;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .PC_INIT(PC_INIT)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .fq    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic cmp_outputs(input logic st, input logic rd);
    logic exp_pop, exp_req;
    exp_pop = (mq.size() != 0) && !st;
    exp_req = ((mq.size() < DEPTH) || exp_pop) && !rd;
    chk("imem_req",  64'(bus.imem_req),  64'(exp_req));
    chk("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
    chk("valid_d",   64'(bus.valid_d),   64'(mq.size() != 0));
    chk("instr_d",   64'(bus.instr_d),   64'((mq.size() != 0) ? mq[0].instr : NOP));
    chk("pc_d",      64'(bus.pc_d),      64'((mq.size() != 0) ? mq[0].pc : 32'h0));
    chk("count",     64'(bus.count),     64'(mq.size()));
  endtask

  // model: redirect wins; otherwise pop the head, then append if a fetch completed
  task automatic model_edge(input logic st, input logic rdy, input logic rd,
                            input logic [31:0] ins, input logic [31:0] rpc);
    logic do_pop, do_req;
    ent_t e;
    if (rd) begin
      mq.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
    end else begin
      do_pop = (mq.size() != 0) && !st;
      do_req = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_req && rdy) begin
        e.pc = m_pc;
        e.instr = ins;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic st, input logic rdy, input logic rd,
                      input logic [31:0] ins, input logic [31:0] rpc);
    @(negedge clk);
    bus.stall_d     = st;
    bus.imem_ready  = rdy;
    bus.redirect    = rd;
    bus.instr       = ins;
    bus.redirect_pc = rpc;
    #1;
    cmp_outputs(st, rd);
    @(posedge clk);
    model_edge(st, rdy, rd, ins, rpc);
  endtask

  initial begin
    logic st, rdy, rd;
    logic [31:0] rpc;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.stall_d = 1'b0;
    bus.imem_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.instr = 32'h0;
    bus.redirect_pc = 32'h0;
    mq.delete();
    m_pc = PC_INIT;

    #3;
    chk("rst_req",   64'(bus.imem_req),  64'(0));
    chk("rst_addr",  64'(bus.imem_addr), 64'(PC_INIT));
    chk("rst_valid", 64'(bus.valid_d),   64'(0));
    chk("rst_instr", 64'(bus.instr_d),   64'(NOP));
    chk("rst_pcd",   64'(bus.pc_d),      64'(0));
    chk("rst_count", 64'(bus.count),     64'(0));
    #4 rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 1'b0, $urandom, 32'h0);
    #1;
    chk("fill_count", 64'(bus.count),     64'(4));
    chk("fill_req",   64'(bus.imem_req),  64'(0));
    chk("fill_addr",  64'(bus.imem_addr), 64'(32'h0040_0010));

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, $urandom, 32'h0);
    #1;
    chk("full_pop_count", 64'(bus.count),     64'(4));
    chk("full_pop_addr",  64'(bus.imem_addr), 64'(32'h0040_001C));

    step(1'b0, 1'b0, 1'b0, $urandom, 32'h0);
    step(1'b0, 1'b1, 1'b1, $urandom, 32'h0040_0103);
    #1;
    chk("redir_addr",  64'(bus.imem_addr), 64'(32'h0040_0100));
    chk("redir_count", 64'(bus.count),     64'(0));
    chk("redir_valid", 64'(bus.valid_d),   64'(0));

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, $urandom, 32'h0);
    step(1'b1, 1'b1, 1'b0, $urandom, 32'h0);
    step(1'b0, 1'b0, 1'b0, $urandom, 32'h0);

    step(1'b0, 1'b1, 1'b1, $urandom, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, $urandom, 32'h0);
    #1;
    chk("wrap_addr", 64'(bus.imem_addr), 64'(0));
    step(1'b1, 1'b1, 1'b0, $urandom, 32'h0);

    @(negedge clk);
    bus.stall_d = 1'b1;
    bus.imem_ready = 1'b0;
    bus.redirect = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bus.valid_d),   64'(0));
    chk("arst_count", 64'(bus.count),     64'(0));
    chk("arst_addr",  64'(bus.imem_addr), 64'(PC_INIT));
    chk("arst_req",   64'(bus.imem_req),  64'(0));
    chk("arst_pcd",   64'(bus.pc_d),      64'(0));
    #1 rst = 1'b0;
    mq.delete();
    m_pc = PC_INIT;

    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      step(st, rdy, rd, $urandom, rpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch queue between the program counter and the decode pipeline register. It owns the fetch PC and issues sequential instruction-memory requests whenever it has room. It buffers up to DEPTH {PC, instruction} pairs and presents them in order to decode under a valid/stall handshake. A single-cycle redirect from execute (branch, JAL, JALR) flushes the queue and restarts fetch, so decode stalls no longer freeze instruction memory.

## Interface
- XLEN, 32, PC and address width.
- DEPTH, 4, queue entries; power of two, ≥ 2.
- PC_INIT, 32'h00400000, fetch PC after reset.

- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ImemAddr  out  XLEN  current fetch PC.
- ImemReq  out  1  fetch request this cycle.
- ImemReady  in  1  memory returns Instr this cycle; a fetch completes when ImemReq & ImemReady.
- Instr  in  32  instruction word, valid in the same cycle as ImemReady.
- Redirect  in  1  flush and restart fetch.
- RedirectPC  in  XLEN  new fetch PC; bits [1:0] are treated as 0.
- InstrD  out  32  head instruction; 32'h00000013 (NOP) when empty.
- PCD  out  XLEN  head PC; 0 when empty.
- ValidD  out  1  head entry valid (Count ≠ 0).
- StallD  in  1  decode not accepting; a pop occurs when ValidD & ~StallD.
- Count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **State:**
  - fetch PC register.
  - DEPTH-entry storage of {PC, Instr}.
  - write/read pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH.
  - Count.
- **ImemReq:**
  - Computed as (Count < DEPTH | pop) & ~Redirect & ~RESET.
  - A full queue still fetches in a cycle where decode pops.
- **Push:**
  - Occurs on ImemReq & ImemReady.
  - Writes {fetch PC, Instr} at the write pointer.
  - Advances the write pointer.
  - Fetch PC += 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0).
- **Pop:**
  - Advances the read pointer.
  - The head output is read combinationally from storage at the read pointer.
  - InstrD and PCD are masked to NOP/0 when Count = 0.
- **Count update:**
  - +1 on push only, −1 on pop only, unchanged on push and pop together.
  - Never exceeds DEPTH and never underflows.
- **Redirect (highest priority):**
  - Sets pointers to 0, Count to 0, and fetch PC to {RedirectPC[XLEN-1:2], 2'b00}.
  - Any same-cycle push or pop is discarded.
  - ImemReq is 0 in that cycle.
- No bypass: an empty queue never forwards Instr combinationally to InstrD.
- **Memory wait (ImemReady = 0):**
  - Fetch PC holds.
  - ImemReq stays asserted while its conditions hold.

## Timing
- Reset values, applied asynchronously and immediately:
  - fetch PC and ImemAddr = PC_INIT.
  - ImemReq = 0.
  - Count = 0, ValidD = 0.
  - InstrD = 32'h00000013, PCD = 0.
- The first request goes out in the first cycle after RESET deasserts.
- Latency: an instruction accepted at edge t is at the head, with ValidD = 1, after edge t (when the queue was empty).
- Sustained throughput: 1 instruction per cycle with ImemReady = 1 and StallD = 0.
- After Redirect at edge t: ImemAddr = RedirectPC and ValidD = 0 after t; the first redirected instruction is valid after t+1.
- RESET asserted mid-operation discards all entries with no pending state.

## Structure
- **Package fetch_pkg:**
  - NOP_INSTR = 32'h00000013.
  - fq_entry_t packed struct {pc[XLEN-1:0], instr[31:0]}.
  - XLEN default.
- **Sub-module fetch_fifo:**
  - Generic DEPTH × fq_entry_t storage with pointers, Count, and synchronous clear.
  - fetch_queue adds the PC register, request logic, redirect priority and output masking.

## Test plan
1. **Reset release:** deassert RESET -> ImemAddr=0x00400000, ImemReq=1, ValidD=0, InstrD=0x00000013, PCD=0, Count=0.
2. **Fill while stalled:** StallD=1, ImemReady=1, DEPTH=4.
   - After 4 edges: Count=4, ImemReq=0, ImemAddr=0x00400010.
   - Then release StallD: PCD is 0x00400000, 04, 08, 0C on successive cycles, with the matching Instr words.
3. **Full with simultaneous pop:** Count=4, StallD=0, ImemReady=1 -> ImemReq=1, Count stays 4, ImemAddr advances by 4 per cycle.
4. **Redirect:** Count=3, ImemReady=1, Redirect=1, RedirectPC=0x00400103.
   - Next cycle: Count=0, ValidD=0, ImemAddr=0x00400100.
   - The same-cycle fetch is not enqueued.
5. **Wait states:** ImemReady=0 for 3 cycles -> ImemAddr and Count unchanged, ImemReq stays 1; the fetch completes on the first ImemReady=1.
6. **PC wrap and async reset:**
   - Redirect to 0xFFFFFFFC, then one fetch -> ImemAddr=0x00000000.
   - A RESET pulse between edges -> ValidD=0, Count=0 and ImemAddr=0x00400000 immediately, without a clock edge.
